decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, default from riscv.h (32), datapath width.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  fetch presents an instruction.
REQ-005 in_ready  out  1  stage accepts the instruction this cycle.
REQ-006 in_instr  in  32  raw RV32I instruction word.
REQ-007 in_pc  in  XLEN  instruction address.
REQ-008 flush  in  1  discard the held and incoming instruction.
REQ-009 out_valid  out  1  decoded bundle valid.
REQ-010 out_ready  in  1  execute stage consumes the bundle.
REQ-011 alu_op  out  4  ALU operation code from alu_codes.h.
REQ-012 rs1, rs2, rd  out  5 each  register indices; rd forced 0 when reg_write=0.
REQ-013 imm  out  XLEN  sign-extended immediate.
REQ-014 in0_sel_pc  out  1  ALU in_0 = pc instead of rs1.
REQ-015 in1_sel_imm  out  1  ALU in_1 = imm instead of rs2.
REQ-016 reg_write, is_load, is_store, is_branch, is_jump  out  1 each  control flags.
REQ-017 funct3_out  out  3  passed through for branch compare and load/store width.
REQ-018 out_pc  out  XLEN  registered copy of in_pc.
REQ-019 illegal  out  1  instruction not decodable as RV32I.

Function
REQ-020 The stage SHALL be a single registered slot; in_ready = !out_valid || out_ready (combinational).
REQ-021 A transfer in SHALL occur when in_valid && in_ready; decoded fields SHALL appear on outputs the next cycle (latency 1).
REQ-022 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-023 Simultaneous consume and accept SHALL replace the slot with no bubble; consume without accept SHALL clear out_valid.
REQ-024 flush SHALL clear out_valid next cycle and block acceptance that cycle, overriding in_valid.
REQ-025 alu_op mapping: OP/OP-IMM by funct3 (ADD/SUB by funct7[5] for OP only, SLL->ALU_LSL, SLT->ALU_LT, SLTU->ALU_LTU, XOR, SRL/SRA by funct7[5], OR, AND).
REQ-026 LUI -> ALU_PASS_1, in1_sel_imm=1; AUIPC, JAL -> ALU_ADD, in0_sel_pc=1, in1_sel_imm=1; JALR, LOAD, STORE -> ALU_ADD, in1_sel_imm=1.
REQ-027 BEQ/BNE -> ALU_SUB; BLT/BGE -> ALU_LT; BLTU/BGEU -> ALU_LTU; in1_sel_imm=0, is_branch=1, reg_write=0.
REQ-028 imm SHALL follow I/S/B/U/J formats, sign bit instr[31]; B/J bit 0 = 0; U low 12 bits = 0.
REQ-029 illegal SHALL assert for unknown opcode, bits[1:0] != 11, invalid funct7 on OP/shift-imm, branch funct3 010/011, load funct3 011/110/111, store funct3 > 010; illegal bundle SHALL have reg_write, is_load, is_store, is_branch, is_jump = 0 and alu_op = ALU_ADD.
REQ-030 reg_write SHALL be 0 when rd decodes to x0.
REQ-031 SYSTEM/FENCE opcodes SHALL decode as legal no-ops (all flags 0, alu_op ALU_ADD).

Reset
REQ-032 On rst, out_valid and all outputs SHALL be 0 next edge; rst overrides flush and in_valid.
REQ-033 in_ready SHALL be 1 the first cycle after rst deasserts.

Structure
REQ-034 ALU codes SHALL come from shared alu_codes.h; opcode constants and XLEN SHALL live in shared riscv.h.
REQ-035 Immediate extraction SHALL be a sub-module imm_gen (instr -> imm, combinational).

Verification
REQ-036 0x00500093 (ADDI x1,x0,5) -> next cycle alu_op=ALU_ADD, rd=1, imm=5, in1_sel_imm=1, reg_write=1.
REQ-037 0x402081B3 (SUB x3,x1,x2) -> alu_op=ALU_SUB, rs1=1, rs2=2, rd=3, in1_sel_imm=0.
REQ-038 0x40335293 (SRAI x5,x6,3) -> alu_op=ALU_ASR, imm[4:0]=3; 0x123453B7 (LUI x7) -> ALU_PASS_1, imm=0x12345000.
REQ-039 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; then out_ready=1 -> back-to-back transfers, no bubble.
REQ-040 0x00000000 -> illegal=1, reg_write=0; flush with slot full and in_valid=1 -> out_valid=0 next cycle, instruction dropped.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I constants for the decode stage: datapath width, major
// opcodes, ALU operation codes and the funct3 -> ALU op helper.
package decode_stage_pkg;

    localparam int RV_XLEN = 32;

    // Major opcodes (instr[6:0]); every legal one ends in 2'b11.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU_ADD is zero so a reset bundle reads as a harmless add.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_LSL    = 4'd2,
        ALU_LSR    = 4'd3,
        ALU_ASR    = 4'd4,
        ALU_LT     = 4'd5,
        ALU_LTU    = 4'd6,
        ALU_XOR    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_1 = 4'd10
    } alu_op_e;

    // alt selects SUB over ADD and ASR over LSR (funct7[5]).
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_LSL;
            3'b010:  return ALU_LT;
            3'b011:  return ALU_LTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_ASR : ALU_LSR;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus the decoded bundle.
// master = environment (fetch + execute), slave = the decode stage.
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int XLEN = RV_XLEN
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            in0_sel_pc;
    logic            in1_sel_imm;
    logic            reg_write;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic [2:0]      funct3_out;
    logic [XLEN-1:0] out_pc;
    logic            illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, alu_op, rs1, rs2, rd, imm, in0_sel_pc,
               in1_sel_imm, reg_write, is_load, is_store, is_branch, is_jump,
               funct3_out, out_pc, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, alu_op, rs1, rs2, rd, imm, in0_sel_pc,
               in1_sel_imm, reg_write, is_load, is_store, is_branch, is_jump,
               funct3_out, out_pc, illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction for the I/S/B/U/J formats, chosen by
// opcode. Formats without an immediate (OP, FENCE, SYSTEM, unknown) give 0.
module decode_stage_imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);
    logic [6:0] w_opcode;
    assign w_opcode = i_instr[6:0];

    // Sign bit is always instr[31]; B/J bit 0 and U low 12 bits are zero.
    always_comb begin
        o_imm = '0;
        case (w_opcode)
            OPC_OP_IMM, OPC_JALR, OPC_LOAD:
                o_imm = {{(XLEN-11){i_instr[31]}}, i_instr[30:20]};
            OPC_STORE:
                o_imm = {{(XLEN-11){i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
            OPC_BRANCH:
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_imm = {{(XLEN-31){i_instr[31]}}, i_instr[30:12], 12'b0};
            OPC_JAL:
                o_imm = {{(XLEN-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one registered slot between fetch and execute.
// Decodes the incoming word combinationally and captures the bundle on a
// transfer; the slot drains or is replaced in the same cycle with no bubble.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = RV_XLEN
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd_field;
    logic [XLEN-1:0] w_imm;
    logic            w_accept;

    alu_op_e         w_alu_op;
    logic            w_in0_sel_pc, w_in1_sel_imm, w_reg_write;
    logic            w_is_load, w_is_store, w_is_branch, w_is_jump, w_illegal;

    logic            r_valid;
    alu_op_e         r_alu_op;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0] r_imm, r_pc;
    logic            r_in0_sel_pc, r_in1_sel_imm, r_reg_write;
    logic            r_is_load, r_is_store, r_is_branch, r_is_jump, r_illegal;
    logic [2:0]      r_funct3;

    assign w_opcode   = bus.in_instr[6:0];
    assign w_rd_field = bus.in_instr[11:7];
    assign w_funct3   = bus.in_instr[14:12];
    assign w_funct7   = bus.in_instr[31:25];

    // Flush discards the incoming word even though in_ready may be high.
    assign bus.in_ready = !r_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready && !bus.flush;

    decode_stage_imm_gen #(.XLEN(XLEN)) imm_gen (
        .i_instr (bus.in_instr),
        .o_imm   (w_imm)
    );

    // Opcode/funct decode; illegal words collapse to an inert ALU_ADD bundle.
    always_comb begin
        w_alu_op      = ALU_ADD;
        w_in0_sel_pc  = 1'b0;
        w_in1_sel_imm = 1'b0;
        w_reg_write   = 1'b0;
        w_is_load     = 1'b0;
        w_is_store    = 1'b0;
        w_is_branch   = 1'b0;
        w_is_jump     = 1'b0;
        w_illegal     = 1'b0;
        // Any word with bits[1:0] != 2'b11 misses every opcode below.
        case (w_opcode)
            OPC_LUI: begin
                w_alu_op      = ALU_PASS_1;
                w_in1_sel_imm = 1'b1;
                w_reg_write   = 1'b1;
            end
            OPC_AUIPC, OPC_JAL: begin
                w_in0_sel_pc  = 1'b1;
                w_in1_sel_imm = 1'b1;
                w_reg_write   = 1'b1;
                w_is_jump     = (w_opcode == OPC_JAL);
            end
            OPC_JALR: begin
                w_in1_sel_imm = 1'b1;
                w_reg_write   = 1'b1;
                w_is_jump     = 1'b1;
            end
            OPC_BRANCH: begin
                w_is_branch = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: w_alu_op = ALU_SUB;
                    3'b100, 3'b101: w_alu_op = ALU_LT;
                    3'b110, 3'b111: w_alu_op = ALU_LTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_in1_sel_imm = 1'b1;
                w_reg_write   = 1'b1;
                w_is_load     = 1'b1;
                w_illegal     = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_in1_sel_imm = 1'b1;
                w_is_store    = 1'b1;
                w_illegal     = (w_funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                // funct7[5] only matters for shifts; ADDI never becomes SUB.
                w_in1_sel_imm = 1'b1;
                w_reg_write   = 1'b1;
                w_alu_op      = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                if (w_funct3 == 3'b001)
                    w_illegal = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
            end
            OPC_OP: begin
                w_reg_write = 1'b1;
                w_alu_op    = alu_from_funct3(w_funct3, w_funct7[5]);
                w_illegal   = !((w_funct7 == 7'b0000000) ||
                                ((w_funct7 == 7'b0100000) &&
                                 ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // Treated as no-ops: nothing to execute in this pipeline.
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_alu_op      = ALU_ADD;
            w_in0_sel_pc  = 1'b0;
            w_in1_sel_imm = 1'b0;
            w_reg_write   = 1'b0;
            w_is_load     = 1'b0;
            w_is_store    = 1'b0;
            w_is_branch   = 1'b0;
            w_is_jump     = 1'b0;
        end
        if (w_rd_field == 5'd0)
            w_reg_write = 1'b0;
    end

    // Slot register: reset clears all, flush empties, accept loads, consume drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= 1'b0;
            r_alu_op      <= ALU_ADD;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_imm         <= '0;
            r_pc          <= '0;
            r_in0_sel_pc  <= 1'b0;
            r_in1_sel_imm <= 1'b0;
            r_reg_write   <= 1'b0;
            r_is_load     <= 1'b0;
            r_is_store    <= 1'b0;
            r_is_branch   <= 1'b0;
            r_is_jump     <= 1'b0;
            r_illegal     <= 1'b0;
            r_funct3      <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_alu_op      <= w_alu_op;
            r_rs1         <= bus.in_instr[19:15];
            r_rs2         <= bus.in_instr[24:20];
            r_rd          <= w_reg_write ? w_rd_field : 5'd0;
            r_imm         <= w_imm;
            r_pc          <= bus.in_pc;
            r_in0_sel_pc  <= w_in0_sel_pc;
            r_in1_sel_imm <= w_in1_sel_imm;
            r_reg_write   <= w_reg_write;
            r_is_load     <= w_is_load;
            r_is_store    <= w_is_store;
            r_is_branch   <= w_is_branch;
            r_is_jump     <= w_is_jump;
            r_illegal     <= w_illegal;
            r_funct3      <= w_funct3;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.alu_op      = r_alu_op;
    assign bus.rs1         = r_rs1;
    assign bus.rs2         = r_rs2;
    assign bus.rd          = r_rd;
    assign bus.imm         = r_imm;
    assign bus.out_pc      = r_pc;
    assign bus.in0_sel_pc  = r_in0_sel_pc;
    assign bus.in1_sel_imm = r_in1_sel_imm;
    assign bus.reg_write   = r_reg_write;
    assign bus.is_load     = r_is_load;
    assign bus.is_store    = r_is_store;
    assign bus.is_branch   = r_is_branch;
    assign bus.is_jump     = r_is_jump;
    assign bus.funct3_out  = r_funct3;
    assign bus.illegal     = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: hand-encoded vector table, stall/flush/reset
// sequences and a random handshake run, all checked through a scoreboard.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [7:0] F_IN0 = 8'h80, F_IN1 = 8'h40, F_RW = 8'h20, F_LD = 8'h10;
    localparam logic [7:0] F_ST  = 8'h08, F_BR  = 8'h04, F_JP = 8'h02, F_ILL = 8'h01;
    localparam int NVEC = 25;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [7:0]  flg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus();
    decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    vec_t tbl [NVEC];
    vec_t sb_q [$];
    logic mdl_valid = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [31:0] instr, input alu_op_e alu, input int rs1,
                                input int rs2, input int rd, input logic [31:0] imm,
                                input int f3, input logic [7:0] flg);
        vec_t v;
        v.instr = instr;
        v.pc    = 32'h0;
        v.alu   = alu;
        v.rs1   = rs1[4:0];
        v.rs2   = rs2[4:0];
        v.rd    = rd[4:0];
        v.imm   = imm;
        v.f3    = f3[2:0];
        v.flg   = flg;
        return v;
    endfunction

    function automatic logic [93:0] exp_bits(input vec_t e);
        return {e.alu, e.rs1, e.rs2, e.rd, e.imm, e.flg, e.f3, e.pc};
    endfunction

    function automatic logic [93:0] dut_bits();
        return {bus.alu_op, bus.rs1, bus.rs2, bus.rd, bus.imm,
                bus.in0_sel_pc, bus.in1_sel_imm, bus.reg_write, bus.is_load,
                bus.is_store, bus.is_branch, bus.is_jump, bus.illegal,
                bus.funct3_out, bus.out_pc};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // One clock cycle, entered at a falling edge: drive, check, predict, advance.
    task automatic cycle(input logic iv, input vec_t v, input logic fl, input logic ordy);
        logic exp_rdy;
        bus.in_valid  = iv;
        bus.in_instr  = v.instr;
        bus.in_pc     = v.pc;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !mdl_valid || ordy;
        check("in_ready", {127'b0, bus.in_ready}, {127'b0, exp_rdy});
        check("out_valid", {127'b0, bus.out_valid}, {127'b0, mdl_valid});
        if (mdl_valid && sb_q.size() > 0)
            check($sformatf("bundle[%08h]", sb_q[0].instr), {34'b0, dut_bits()},
                  {34'b0, exp_bits(sb_q[0])});
        if (fl) begin
            sb_q.delete();
            mdl_valid = 1'b0;
        end else begin
            if (mdl_valid && ordy) begin
                $display("retire pc=%08h instr=%08h", sb_q[0].pc, sb_q[0].instr);
                void'(sb_q.pop_front());
                mdl_valid = 1'b0;
            end
            if (iv && exp_rdy) begin
                sb_q.push_back(v);
                mdl_valid = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        logic r_iv, r_fl, r_rdy;

        idle = '0;
        tbl[0]  = mk(32'h00500093, ALU_ADD,    0,  5,  1, 32'h00000005, 0, F_IN1 | F_RW);
        tbl[1]  = mk(32'h402081B3, ALU_SUB,    1,  2,  3, 32'h00000000, 0, F_RW);
        tbl[2]  = mk(32'h40335293, ALU_ASR,    6,  3,  5, 32'h00000403, 5, F_IN1 | F_RW);
        tbl[3]  = mk(32'h123453B7, ALU_PASS_1, 8,  3,  7, 32'h12345000, 5, F_IN1 | F_RW);
        tbl[4]  = mk(32'h00000000, ALU_ADD,    0,  0,  0, 32'h00000000, 0, F_ILL);
        tbl[5]  = mk(32'h0020A233, ALU_LT,     1,  2,  4, 32'h00000000, 2, F_RW);
        tbl[6]  = mk(32'hFE209EE3, ALU_SUB,    1,  2,  0, 32'hFFFFFFFC, 1, F_BR);
        tbl[7]  = mk(32'hFE20FEE3, ALU_LTU,    1,  2,  0, 32'hFFFFFFFC, 7, F_BR);
        tbl[8]  = mk(32'h0020A423, ALU_ADD,    1,  2,  0, 32'h00000008, 2, F_IN1 | F_ST);
        tbl[9]  = mk(32'hFFF0A283, ALU_ADD,    1, 31,  5, 32'hFFFFFFFF, 2, F_IN1 | F_RW | F_LD);
        tbl[10] = mk(32'h008000EF, ALU_ADD,    0,  8,  1, 32'h00000008, 0, F_IN0 | F_IN1 | F_RW | F_JP);
        tbl[11] = mk(32'hFFDFF06F, ALU_ADD,   31, 29,  0, 32'hFFFFFFFC, 7, F_IN0 | F_IN1 | F_JP);
        tbl[12] = mk(32'h00001517, ALU_ADD,    0,  0, 10, 32'h00001000, 1, F_IN0 | F_IN1 | F_RW);
        tbl[13] = mk(32'h000280E7, ALU_ADD,    5,  0,  1, 32'h00000000, 0, F_IN1 | F_RW | F_JP);
        tbl[14] = mk(32'h021080B3, ALU_ADD,    1,  1,  0, 32'h00000000, 0, F_ILL);
        tbl[15] = mk(32'hFE20AEE3, ALU_ADD,    1,  2,  0, 32'hFFFFFFFC, 2, F_ILL);
        tbl[16] = mk(32'hFFF0B283, ALU_ADD,    1, 31,  0, 32'hFFFFFFFF, 3, F_ILL);
        tbl[17] = mk(32'h0020B423, ALU_ADD,    1,  2,  0, 32'h00000008, 3, F_ILL);
        tbl[18] = mk(32'h00500091, ALU_ADD,    0,  5,  0, 32'h00000000, 0, F_ILL);
        tbl[19] = mk(32'h40131293, ALU_ADD,    6,  1,  0, 32'h00000401, 1, F_ILL);
        tbl[20] = mk(32'h0FF0000F, ALU_ADD,    0, 31,  0, 32'h00000000, 0, 8'h00);
        tbl[21] = mk(32'h00000073, ALU_ADD,    0,  0,  0, 32'h00000000, 0, 8'h00);
        tbl[22] = mk(32'h4020D1B3, ALU_ASR,    1,  2,  3, 32'h00000000, 5, F_RW);
        tbl[23] = mk(32'hFFF0C113, ALU_XOR,    1, 31,  2, 32'hFFFFFFFF, 4, F_IN1 | F_RW);
        tbl[24] = mk(32'h40000093, ALU_ADD,    0,  0,  1, 32'h00000400, 0, F_IN1 | F_RW);
        for (int i = 0; i < NVEC; i++) tbl[i].pc = 32'h1000 + 32'(4 * i);

        // Reset state.
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = tbl[0].instr; bus.in_pc = 32'h40;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("reset_outputs", {34'b0, dut_bits()}, 128'd0);
        rst = 1'b0;

        // Whole table streamed back to back with execute always ready.
        for (int i = 0; i < NVEC; i++) cycle(1'b1, tbl[i], 1'b0, 1'b1);
        cycle(1'b0, idle, 1'b0, 1'b1);

        // Execute stalls for 3 cycles with fetch offering SUB, then streams.
        cycle(1'b1, tbl[0], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, tbl[1], 1'b0, 1'b0);
        cycle(1'b1, tbl[1], 1'b0, 1'b1);
        cycle(1'b1, tbl[2], 1'b0, 1'b1);
        cycle(1'b1, tbl[3], 1'b0, 1'b1);
        cycle(1'b0, idle,   1'b0, 1'b1);
        cycle(1'b0, idle,   1'b0, 1'b1);

        // Flush with slot full and a new word offered: both discarded.
        cycle(1'b1, tbl[0], 1'b0, 1'b0);
        cycle(1'b1, tbl[1], 1'b1, 1'b0);
        cycle(1'b0, idle,   1'b0, 1'b1);
        // Flush with empty slot: incoming word dropped.
        cycle(1'b1, tbl[5], 1'b1, 1'b1);
        cycle(1'b1, tbl[9], 1'b0, 1'b1);
        cycle(1'b0, idle,   1'b0, 1'b0);

        // Reset overrides a full slot, in_valid and flush together.
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_instr = tbl[3].instr; bus.in_pc = 32'h80;
        bus.flush = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("midreset_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("midreset_outputs", {34'b0, dut_bits()}, 128'd0);
        sb_q.delete();
        mdl_valid = 1'b0;
        rst = 1'b0;
        // First cycle out of reset: in_ready must be 1 even with out_ready low.
        cycle(1'b0, idle, 1'b0, 1'b0);

        // Random handshake traffic over the table.
        for (int k = 0; k < 120; k++) begin
            v = tbl[$urandom_range(NVEC - 1, 0)];
            v.pc  = $urandom;
            r_iv  = ($urandom_range(3, 0) != 0);
            r_fl  = ($urandom_range(11, 0) == 0);
            r_rdy = ($urandom_range(2, 0) != 0);
            cycle(r_iv, v, r_fl, r_rdy);
        end
        cycle(1'b0, idle, 1'b0, 1'b1);
        cycle(1'b0, idle, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
